// File: rtl/fpu_defs.sv
// Shared FPU widths, result-buffer defaults and the buffered entry layout.
package fpu_defs;

    localparam int unsigned C_OP       = 64;
    localparam int unsigned C_FLAG     = 10;
    localparam int unsigned C_TAG      = 8;
    localparam int unsigned C_RB_DEPTH = 4;
    localparam int unsigned C_RB_SKID  = 2;

    typedef struct packed {
        logic [C_OP-1:0]   result;
        logic [C_FLAG-1:0] flags;
        logic [C_TAG-1:0]  tag;
    } rb_entry_t;

endpackage

// File: rtl/fpu_result_buffer.sv
// FIFO of FPU results: 1-cycle push-to-valid latency, valid/ready drain; upstream throttled
// via IssueReady_SO with SKID slots of headroom, results arriving at full are dropped and flagged.
module fpu_result_buffer
    import fpu_defs::*;
#(
    parameter int unsigned DEPTH = C_RB_DEPTH,
    parameter int unsigned SKID  = C_RB_SKID
) (
    input  logic                        Clk_CI,
    input  logic                        Rst_RBI,
    input  logic                        Req_SI,
    input  logic [C_OP-1:0]             Result_DI,
    input  logic [C_FLAG-1:0]           Flags_DI,
    input  logic [C_TAG-1:0]            Tag_DI,
    output logic                        IssueReady_SO,
    output logic                        Valid_SO,
    input  logic                        Ready_SI,
    output logic [C_OP-1:0]             Result_DO,
    output logic [C_FLAG-1:0]           Flags_DO,
    output logic [C_TAG-1:0]            Tag_DO,
    output logic [$clog2(DEPTH+1)-1:0]  Count_SO,
    output logic [C_FLAG-1:0]           FlagsAcc_DO,
    output logic                        Overflow_SO,
    input  logic                        ClearErr_SI
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    rb_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     cnt_q,  cnt_d;
    logic [C_FLAG-1:0] facc_q, facc_d;
    logic              ovf_q,  ovf_d;

    logic      valid, full, pop, push, lost;
    rb_entry_t head;

    assign valid = (cnt_q != '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign pop   = valid && Ready_SI;
    // A pop frees the slot in the same cycle, so a full buffer still takes a result when draining.
    assign push  = Req_SI && (!full || pop);
    assign lost  = Req_SI && full && !pop;
    assign head  = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        facc_d = facc_q;
        ovf_d  = ovf_q;
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);
        if (ClearErr_SI) begin
            facc_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (pop)  facc_d = facc_q | head.flags;
            if (lost) ovf_d  = 1'b1;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            facc_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            facc_q <= facc_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage carries no reset; stale slots are never visible because outputs are masked by valid.
    always_ff @(posedge Clk_CI) begin
        if (push && Rst_RBI) mem_q[wptr_q] <= '{result: Result_DI, flags: Flags_DI, tag: Tag_DI};
    end

    assign Valid_SO      = valid;
    assign Count_SO      = cnt_q;
    assign IssueReady_SO = (cnt_q < CW'(DEPTH - SKID));
    assign FlagsAcc_DO   = facc_q;
    assign Overflow_SO   = ovf_q;
    assign Result_DO     = valid ? head.result : '0;
    assign Flags_DO      = valid ? head.flags  : '0;
    assign Tag_DO        = valid ? head.tag    : '0;

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Randomized and directed bench for fpu_result_buffer against a queue-based reference model.
module tb_fpu_result_buffer;
    import fpu_defs::*;

    localparam int unsigned DEPTH = C_RB_DEPTH;
    localparam int unsigned SKID  = C_RB_SKID;
    localparam int unsigned CW    = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req, rdy, clr;
    logic [C_OP-1:0]   res_in;
    logic [C_FLAG-1:0] flg_in;
    logic [C_TAG-1:0]  tag_in;
    logic              issue_rdy, vld;
    logic [C_OP-1:0]   res_out;
    logic [C_FLAG-1:0] flg_out, facc;
    logic [C_TAG-1:0]  tag_out;
    logic [CW-1:0]     cnt;
    logic              ovf;

    int checks = 0;
    int errors = 0;

    rb_entry_t         mq[$];
    logic [C_FLAG-1:0] m_facc = '0;
    logic              m_ovf  = 1'b0;

    fpu_result_buffer #(.DEPTH(DEPTH), .SKID(SKID)) dut (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Req_SI(req), .Result_DI(res_in),
        .Flags_DI(flg_in), .Tag_DI(tag_in), .IssueReady_SO(issue_rdy),
        .Valid_SO(vld), .Ready_SI(rdy), .Result_DO(res_out), .Flags_DO(flg_out),
        .Tag_DO(tag_out), .Count_SO(cnt), .FlagsAcc_DO(facc),
        .Overflow_SO(ovf), .ClearErr_SI(clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare every output against the model, apply new inputs, then advance the model one clock.
    task automatic cyc(input logic r_n, input logic rq, input logic rd, input logic cl,
                       input logic [C_TAG-1:0] tg, input logic [C_FLAG-1:0] fl);
        rb_entry_t e;
        bit        m_pop, m_push, m_lost;
        logic [C_FLAG-1:0] pflags;
        @(negedge clk);
        chk("count",   64'(cnt),       64'(mq.size()));
        chk("valid",   64'(vld),       64'(mq.size() != 0));
        chk("issue",   64'(issue_rdy), 64'(mq.size() < DEPTH - SKID));
        chk("result",  64'(res_out),   mq.size() != 0 ? 64'(mq[0].result) : 64'd0);
        chk("flags",   64'(flg_out),   mq.size() != 0 ? 64'(mq[0].flags)  : 64'd0);
        chk("tag",     64'(tag_out),   mq.size() != 0 ? 64'(mq[0].tag)    : 64'd0);
        chk("flagacc", 64'(facc),      64'(m_facc));
        chk("ovf",     64'(ovf),       64'(m_ovf));

        rst_n  = r_n;
        req    = rq;
        rdy    = rd;
        clr    = cl;
        tag_in = tg;
        flg_in = fl;
        res_in = {$urandom, $urandom};

        if (!r_n) begin
            mq.delete();
            m_facc = '0;
            m_ovf  = 1'b0;
        end else begin
            m_pop  = (mq.size() != 0) && rd;
            pflags = m_pop ? mq[0].flags : '0;
            m_push = rq && (mq.size() < DEPTH || m_pop);
            m_lost = rq && !m_push;
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                e.result = res_in; e.flags = fl; e.tag = tg;
                mq.push_back(e);
            end
            if (cl) begin
                m_facc = '0;
                m_ovf  = 1'b0;
            end else begin
                m_facc = m_facc | pflags;
                if (m_lost) m_ovf = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
        chk("drained", 64'(cnt), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; rdy = 1'b0; clr = 1'b0;
        res_in = '0; flg_in = '0; tag_in = '0;
        @(posedge clk);
        do_reset();
        chk("rst_issue", 64'(issue_rdy), 64'd1);
        chk("rst_valid", 64'(vld), 64'd0);

        // Three pushes with consumer stalled.
        for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, C_TAG'(i), '0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("fill3_cnt", 64'(cnt), 64'd3);
        chk("fill3_tag", 64'(tag_out), 64'd1);
        chk("fill3_issue", 64'(issue_rdy), 64'd0);
        drain();

        // Streaming with ready held high; pointers wrap more than twice.
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, C_TAG'(i), '0);
        drain();

        // Full with simultaneous push and pop, then overflow.
        for (int i = 0; i < int'(DEPTH); i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, C_TAG'(8'h20 + i), '0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, C_TAG'(8'h30 + i), '0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h07, '0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("ovf_set", 64'(ovf), 64'd1);
        chk("ovf_cnt", 64'(cnt), 64'(DEPTH));
        drain();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);

        // Sticky flag accumulation and clear-wins.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h41, 10'h004);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h42, 10'h100);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h43, 10'h002);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, '0, '0);
        chk("facc_104", 64'(facc), 64'h104);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("facc_clr", 64'(facc), 64'd0);

        // Reset mid-operation with a request present.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, C_TAG'(8'h50 + i), 10'h3ff);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 10'h001);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("mrst_cnt", 64'(cnt), 64'd0);
        chk("mrst_tag", 64'(tag_out), 64'd0);
        chk("mrst_issue", 64'(issue_rdy), 64'd1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) != 0),
                ($urandom_range(0, 99) < 60),
                ($urandom_range(0, 99) < 45),
                ($urandom_range(0, 29) == 0),
                C_TAG'($urandom), C_FLAG'($urandom));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
